// File: rtl/goertzel_spectrum_collector.sv
// Captures per-bin Goertzel results as saturated magnitudes and streams a full frame as NF beats, then reports the peak.
// First beat 1 cycle after the last flag registers; m_ready low holds the beat, and new bin edges during streaming are dropped into overrun.
module goertzel_spectrum_collector #(
    parameter  int NF = 11,
    parameter  int DW = 32,
    localparam int IW = $clog2(NF)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [NF-1:0]    valid_i,
    input  logic [NF*DW-1:0] data_i,
    input  logic             clear,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [IW-1:0]    m_idx,
    output logic [DW-1:0]    m_data,
    output logic             m_last,
    output logic             done,
    output logic [IW-1:0]    peak_idx,
    output logic [DW-1:0]    peak_mag,
    output logic             overrun
);

    typedef enum logic [1:0] {S_COLLECT, S_STREAM, S_DONE} state_t;

    state_t          state;
    logic [NF-1:0]   valid_d;
    logic [NF-1:0]   flag;
    logic [NF-1:0]   rise;
    logic [DW-1:0]   mag     [NF];
    logic [DW-1:0]   cap_mag [NF];
    logic [DW-1:0]   run_mag;
    logic [IW-1:0]   run_idx;
    logic [IW-1:0]   nxt_idx;
    logic            beat_gt;
    logic [DW-1:0]   new_mag;
    logic [IW-1:0]   new_idx;

    // The most negative value has no positive twin, so it clips to the largest positive.
    function automatic logic [DW-1:0] abs_sat(input logic [DW-1:0] x);
        if (x == {1'b1, {(DW-1){1'b0}}})
            return {1'b0, {(DW-1){1'b1}}};
        else if (x[DW-1])
            return -x;
        else
            return x;
    endfunction

    assign rise    = valid_i & ~valid_d;
    assign nxt_idx = m_idx + IW'(1);
    assign beat_gt = m_data > run_mag;
    assign new_mag = beat_gt ? m_data : run_mag;
    assign new_idx = beat_gt ? m_idx : run_idx;

    always_comb begin
        for (int k = 0; k < NF; k++)
            cap_mag[k] = abs_sat(data_i[k*DW +: DW]);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_COLLECT;
            valid_d  <= '0;
            flag     <= '0;
            for (int k = 0; k < NF; k++)
                mag[k] <= '0;
            run_mag  <= '0;
            run_idx  <= '0;
            m_valid  <= 1'b0;
            m_idx    <= '0;
            m_data   <= '0;
            m_last   <= 1'b0;
            done     <= 1'b0;
            peak_idx <= '0;
            peak_mag <= '0;
            overrun  <= 1'b0;
        end else begin
            valid_d <= valid_i;
            if (clear) begin
                state   <= S_COLLECT;
                flag    <= '0;
                m_valid <= 1'b0;
                m_last  <= 1'b0;
                done    <= 1'b0;
                overrun <= 1'b0;
                run_mag <= '0;
                run_idx <= '0;
            end else begin
                case (state)
                    S_COLLECT: begin
                        for (int k = 0; k < NF; k++) begin
                            if (rise[k]) begin
                                mag[k]  <= cap_mag[k];
                                flag[k] <= 1'b1;
                            end
                        end
                        if (&flag) begin
                            state   <= S_STREAM;
                            m_valid <= 1'b1;
                            m_idx   <= '0;
                            // A bin-0 refresh in this same cycle must not be missed by the first beat.
                            m_data  <= rise[0] ? cap_mag[0] : mag[0];
                            m_last  <= (NF == 1);
                            run_mag <= '0;
                            run_idx <= '0;
                        end
                    end
                    S_STREAM: begin
                        if (|rise)
                            overrun <= 1'b1;
                        if (m_valid && m_ready) begin
                            run_mag <= new_mag;
                            run_idx <= new_idx;
                            if (m_last) begin
                                state    <= S_DONE;
                                m_valid  <= 1'b0;
                                m_last   <= 1'b0;
                                done     <= 1'b1;
                                peak_idx <= new_idx;
                                peak_mag <= new_mag;
                            end else begin
                                m_idx  <= nxt_idx;
                                m_data <= mag[nxt_idx];
                                m_last <= (nxt_idx == IW'(NF-1));
                            end
                        end
                    end
                    S_DONE: begin
                        if (|rise)
                            overrun <= 1'b1;
                        done  <= 1'b0;
                        flag  <= '0;
                        state <= S_COLLECT;
                    end
                    default: state <= S_COLLECT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_goertzel_spectrum_collector.sv
// Directed bench: expected beats and peaks are queued by the stimulus and checked by a negedge monitor.
module tb_goertzel_spectrum_collector;

    localparam int NF = 11;
    localparam int DW = 32;
    localparam int IW = $clog2(NF);

    logic             clk;
    logic             rstn;
    logic [NF-1:0]    valid_i;
    logic [NF*DW-1:0] data_i;
    logic             clear;
    logic             m_valid;
    logic             m_ready;
    logic [IW-1:0]    m_idx;
    logic [DW-1:0]    m_data;
    logic             m_last;
    logic             done;
    logic [IW-1:0]    peak_idx;
    logic [DW-1:0]    peak_mag;
    logic             overrun;

    goertzel_spectrum_collector #(.NF(NF), .DW(DW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .valid_i  (valid_i),
        .data_i   (data_i),
        .clear    (clear),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_idx    (m_idx),
        .m_data   (m_data),
        .m_last   (m_last),
        .done     (done),
        .peak_idx (peak_idx),
        .peak_mag (peak_mag),
        .overrun  (overrun)
    );

    typedef struct {
        int          idx;
        logic [31:0] dat;
        bit          last;
    } beat_t;

    typedef struct {
        int          idx;
        logic [31:0] mag;
    } pk_t;

    beat_t exp_q[$];
    pk_t   pk_q[$];
    bit    exp_done_next;
    int    xfer_cnt;
    int    n_cmp;
    int    n_bad;
    int    rdy_mode;
    int    rcnt;

    logic [31:0] basic_d [NF];
    logic [31:0] basic_m [NF];
    logic [31:0] sat_d   [NF];
    logic [31:0] sat_m   [NF];
    logic [31:0] ramp_d  [NF];
    logic [31:0] ramp_m  [NF];
    logic [31:0] lvl_d   [NF];
    logic [31:0] lvl_m   [NF];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Backpressure pattern driver: always ready, or 1,0,0 repeating.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) begin
                m_ready = 1'b1;
            end else begin
                m_ready = (rcnt % 3 == 0);
                rcnt++;
            end
        end
    end

    // Monitor: every presented beat must match the queue head, including while stalled.
    beat_t e;
    pk_t   p;
    always @(negedge clk) begin
        if (rstn) begin
            if (exp_done_next || done) begin
                chk("done_pulse", {31'd0, done}, {31'd0, exp_done_next});
                if (exp_done_next && done) begin
                    if (pk_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL peak_unexpected: got idx %0d mag %0h expected none", peak_idx, peak_mag);
                    end else begin
                        p = pk_q.pop_front();
                        chk("peak_idx", {28'd0, peak_idx}, p.idx);
                        chk("peak_mag", peak_mag, p.mag);
                    end
                end
                exp_done_next = 1'b0;
            end
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL beat_unexpected: got idx %0d data %0h expected no beat", m_idx, m_data);
                end else begin
                    e = exp_q[0];
                    chk("beat_idx", {28'd0, m_idx}, e.idx);
                    chk("beat_data", m_data, e.dat);
                    chk("beat_last", {31'd0, m_last}, {31'd0, e.last});
                    if (m_ready) begin
                        void'(exp_q.pop_front());
                        xfer_cnt++;
                        if (e.last)
                            exp_done_next = 1'b1;
                    end
                end
            end
        end
    end

    task automatic expect_frame(input logic [31:0] m [NF], input int pi, input logic [31:0] pm);
        beat_t b;
        pk_t   q;
        for (int k = 0; k < NF; k++) begin
            b.idx  = k;
            b.dat  = m[k];
            b.last = (k == NF-1);
            exp_q.push_back(b);
        end
        q.idx = pi;
        q.mag = pm;
        pk_q.push_back(q);
    endtask

    task automatic send_frame(input logic [31:0] d [NF], input bit at_once);
        for (int k = 0; k < NF; k++)
            data_i[k*DW +: DW] = d[k];
        if (at_once) begin
            valid_i = '1;
            tick();
        end else begin
            for (int k = 0; k < NF; k++) begin
                valid_i[k] = 1'b1;
                tick();
            end
        end
    endtask

    task automatic wait_frame(input string nm);
        int i;
        for (i = 0; i < 400 && (exp_q.size() != 0 || pk_q.size() != 0 || exp_done_next); i++)
            tick();
        if (exp_q.size() != 0 || pk_q.size() != 0 || exp_done_next) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got %0d beats pending expected 0", nm, exp_q.size());
            flush();
        end
    endtask

    task automatic wait_valid(input string nm);
        int i;
        for (i = 0; i < 100 && !m_valid; i++)
            tick();
        if (!m_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_no_valid: got m_valid 0 expected 1", nm);
        end
    endtask

    task automatic flush();
        exp_q.delete();
        pk_q.delete();
        exp_done_next = 1'b0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_m_valid"},  {31'd0, m_valid}, 32'd0);
        chk({nm, "_m_idx"},    {28'd0, m_idx}, 32'd0);
        chk({nm, "_m_data"},   m_data, 32'd0);
        chk({nm, "_m_last"},   {31'd0, m_last}, 32'd0);
        chk({nm, "_done"},     {31'd0, done}, 32'd0);
        chk({nm, "_peak_idx"}, {28'd0, peak_idx}, 32'd0);
        chk({nm, "_peak_mag"}, peak_mag, 32'd0);
        chk({nm, "_overrun"},  {31'd0, overrun}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        n_cmp = 0;
        n_bad = 0;
        xfer_cnt = 0;
        rdy_mode = 0;
        rcnt = 0;
        exp_done_next = 1'b0;
        rstn = 1'b0;
        valid_i = '0;
        data_i = '0;
        clear = 1'b0;

        basic_m = '{32'd500, 32'd400, 32'd300, 32'd200, 32'd100, 32'd0,
                    32'd100, 32'd200, 32'd300, 32'd400, 32'd500};
        ramp_m  = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6,
                    32'd7, 32'd8, 32'd9, 32'd10, 32'd11};
        sat_m   = '{32'd1, 32'd1, 32'd1, 32'h7FFF_FFFF, 32'd1, 32'd1,
                    32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
        lvl_m   = '{32'd7, 32'd7, 32'd7, 32'd7, 32'd7, 32'd7,
                    32'd7, 32'd7, 32'd7, 32'd7, 32'd7};
        for (int k = 0; k < NF; k++) begin
            basic_d[k] = 32'(k * 100 - 500);
            ramp_d[k]  = 32'(k + 1);
            sat_d[k]   = (k == 3) ? 32'h8000_0000 : 32'd1;
            lvl_d[k]   = (k % 2 == 0) ? 32'd7 : 32'hFFFF_FFF9;
        end

        // Reset values
        tick();
        tick();
        chk_all_zero("reset");
        rstn = 1'b1;
        tick();

        // Basic frame, one bin per cycle, continuous ready
        expect_frame(basic_m, 0, 32'd500);
        send_frame(basic_d, 1'b0);
        wait_frame("basic");
        valid_i = '0;
        tick();

        // Backpressure 1,0,0 pattern
        rdy_mode = 1;
        rcnt = 0;
        base = xfer_cnt;
        expect_frame(basic_m, 0, 32'd500);
        send_frame(basic_d, 1'b0);
        wait_frame("bp");
        chk("bp_xfer_count", xfer_cnt - base, 32'd11);
        rdy_mode = 0;
        valid_i = '0;
        tick();

        // Saturation of the most negative value
        expect_frame(sat_m, 3, 32'h7FFF_FFFF);
        send_frame(sat_d, 1'b0);
        wait_frame("sat");
        valid_i = '0;
        tick();

        // Overrun: re-edge bin 2 while streaming slowly
        rdy_mode = 1;
        rcnt = 0;
        expect_frame(ramp_m, 10, 32'd11);
        send_frame(ramp_d, 1'b0);
        wait_valid("ovr");
        valid_i[2] = 1'b0;
        tick();
        data_i[2*DW +: DW] = 32'd999;
        valid_i[2] = 1'b1;
        tick();
        tick();
        chk("ovr_set", {31'd0, overrun}, 32'd1);
        wait_frame("ovr");
        chk("ovr_sticky_a", {31'd0, overrun}, 32'd1);
        rdy_mode = 0;
        valid_i = '0;
        tick();
        expect_frame(basic_m, 0, 32'd500);
        send_frame(basic_d, 1'b0);
        wait_frame("ovr_next");
        chk("ovr_sticky_b", {31'd0, overrun}, 32'd1);
        valid_i = '0;
        tick();

        // Level: all bins rise together and stay high; only one frame
        expect_frame(lvl_m, 0, 32'd7);
        send_frame(lvl_d, 1'b1);
        wait_frame("lvl");
        repeat (30) tick();
        chk("lvl_no_second", {31'd0, m_valid}, 32'd0);

        // Clear after beat 4
        valid_i = '0;
        tick();
        base = xfer_cnt;
        expect_frame(ramp_m, 10, 32'd11);
        send_frame(ramp_d, 1'b1);
        for (int i = 0; i < 100 && xfer_cnt < base + 5; i++)
            tick();
        chk("clr_reached_beat4", {31'd0, (xfer_cnt >= base + 5)}, 32'd1);
        chk("clr_ovr_before", {31'd0, overrun}, 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        flush();
        chk("clr_m_valid", {31'd0, m_valid}, 32'd0);
        chk("clr_overrun", {31'd0, overrun}, 32'd0);
        chk("clr_peak_idx", {28'd0, peak_idx}, 32'd0);
        chk("clr_peak_mag", peak_mag, 32'd7);
        valid_i = '0;
        tick();
        expect_frame(basic_m, 0, 32'd500);
        send_frame(basic_d, 1'b0);
        wait_frame("clr_next");
        valid_i = '0;
        tick();

        // Reset in the middle of a slow stream
        rdy_mode = 1;
        rcnt = 0;
        expect_frame(ramp_m, 10, 32'd11);
        send_frame(ramp_d, 1'b1);
        wait_valid("rst");
        repeat (4) tick();
        rstn = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        flush();
        valid_i = '0;
        rdy_mode = 0;
        tick();
        rstn = 1'b1;
        tick();
        expect_frame(sat_m, 3, 32'h7FFF_FFFF);
        send_frame(sat_d, 1'b0);
        wait_frame("rst_next");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
